// File: rtl/lut4_pkg.sv
// Shared definitions for the LUT4 configuration readback path.
package lut4_pkg;

    localparam int         LUT_W     = 16;
    localparam logic [7:0] RB_HEADER = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        CNT,
        DATA,
        CSUM,
        DONE
    } rb_state_t;

    // Header + count + checksum bytes plus one table per LUT.
    function automatic int rb_frame_bits(input int num_luts);
        return 24 + LUT_W * num_luts;
    endfunction

endpackage

// File: rtl/lut4_rb_bitclk.sv
// Serial bit timing: sclk_o low for the first half of each bit, high for the second,
// with a one-cycle bit_adv strobe in the last cycle of the bit.
module lut4_rb_bitclk #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic sclk_o,
    output logic bit_adv
);

    localparam int            PW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PH_HALF = PW'(CLK_DIV / 2);

    logic [PW-1:0] phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (!run || bit_adv) begin
            phase <= '0;
        end else begin
            phase <= phase + PW'(1);
        end
    end

    assign bit_adv = run && (phase == PH_LAST);
    assign sclk_o  = run && (phase >= PH_HALF);

endmodule

// File: rtl/lut4_cfg_readback.sv
// Snapshots the LUT4 truth tables on request and shifts them out MSB first as
// A5 | count | tables (LUT0 first) | XOR checksum of count and table bytes.
//
// state | meaning
// IDLE  | waiting for rd_req with ena high
// HDR   | shifting header byte A5
// CNT   | shifting the LUT count byte
// DATA  | shifting 16-bit table lut_idx
// CSUM  | shifting the checksum byte
// DONE  | one-cycle done pulse, outputs quiet
module lut4_cfg_readback
    import lut4_pkg::*;
#(
    parameter int NUM_LUTS = 4,
    parameter int CLK_DIV  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic                      rd_req,
    input  logic [LUT_W*NUM_LUTS-1:0] cfg_tables,
    output logic                      busy,
    output logic                      done,
    output logic                      frame_o,
    output logic                      sclk_o,
    output logic                      sdo
);

    localparam logic [7:0] CNT_BYTE = 8'(NUM_LUTS);
    localparam logic [3:0] LUT_LAST = 4'(NUM_LUTS - 1);

    rb_state_t                 state, state_nxt;
    logic [LUT_W*NUM_LUTS-1:0] snap;
    logic [3:0]                bit_idx, bit_idx_nxt;
    logic [3:0]                lut_idx, lut_idx_nxt;
    logic [7:0]                csum, csum_nxt;
    logic [LUT_W-1:0]          cur_tbl;
    logic                      bit_adv;
    logic                      field_end;
    logic                      start;

    lut4_rb_bitclk #(.CLK_DIV(CLK_DIV)) u_bitclk (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (busy && ena),
        .sclk_o  (sclk_o),
        .bit_adv (bit_adv)
    );

    assign start     = rd_req && ena && (state == IDLE);
    assign field_end = bit_adv && (bit_idx == 4'd0);
    assign frame_o   = busy;

    always_comb begin
        cur_tbl = '0;
        for (int i = 0; i < NUM_LUTS; i++) begin
            if (lut_idx == 4'(i)) cur_tbl = snap[i*LUT_W +: LUT_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_idx <= '0;
            lut_idx <= '0;
            csum    <= '0;
        end else begin
            state   <= state_nxt;
            bit_idx <= bit_idx_nxt;
            lut_idx <= lut_idx_nxt;
            csum    <= csum_nxt;
        end
    end

    // Frame content comes only from this copy, so host writes mid-frame are invisible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap <= '0;
        end else if (start) begin
            snap <= cfg_tables;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_idx_nxt = bit_idx;
        lut_idx_nxt = lut_idx;
        csum_nxt    = csum;
        busy        = 1'b0;
        done        = 1'b0;
        sdo         = 1'b0;

        if (bit_adv && bit_idx != 4'd0) bit_idx_nxt = bit_idx - 4'd1;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = HDR;
                    bit_idx_nxt = 4'd7;
                    lut_idx_nxt = '0;
                    csum_nxt    = '0;
                end
            end
            HDR: begin
                busy = 1'b1;
                sdo  = RB_HEADER[bit_idx[2:0]];
                if (field_end) begin
                    state_nxt   = CNT;
                    bit_idx_nxt = 4'd7;
                    csum_nxt    = CNT_BYTE;
                end
            end
            CNT: begin
                busy = 1'b1;
                sdo  = CNT_BYTE[bit_idx[2:0]];
                if (field_end) begin
                    state_nxt   = DATA;
                    bit_idx_nxt = 4'd15;
                    lut_idx_nxt = '0;
                end
            end
            DATA: begin
                busy = 1'b1;
                sdo  = cur_tbl[bit_idx];
                if (field_end) begin
                    csum_nxt = csum ^ cur_tbl[15:8] ^ cur_tbl[7:0];
                    if (lut_idx == LUT_LAST) begin
                        state_nxt   = CSUM;
                        bit_idx_nxt = 4'd7;
                        lut_idx_nxt = '0;
                    end else begin
                        bit_idx_nxt = 4'd15;
                        lut_idx_nxt = lut_idx + 4'd1;
                    end
                end
            end
            CSUM: begin
                busy = 1'b1;
                sdo  = csum[bit_idx[2:0]];
                if (field_end) begin
                    state_nxt   = DONE;
                    bit_idx_nxt = '0;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
                csum_nxt  = '0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (!ena) begin
            state_nxt   = IDLE;
            bit_idx_nxt = '0;
            lut_idx_nxt = '0;
            csum_nxt    = '0;
        end
    end

endmodule

// File: tb/tb_lut4_cfg_readback.sv
// Directed bench for lut4_cfg_readback: receives frames on sclk_o rising edges and
// compares them against bytes queued from a reference frame builder.
module tb_lut4_cfg_readback;
    import lut4_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic        rd_req = 1'b0;
    logic        sel = 1'b0;
    logic [63:0] cfg4 = '0;
    logic [15:0] cfg1 = '0;

    logic busy4, done4, frame4, sclk4, sdo4;
    logic busy1, done1, frame1, sclk1, sdo1;
    logic rd4, rd1;
    logic m_busy, m_done, m_frame, m_sclk, m_sdo;

    assign rd4     = sel ? 1'b0 : rd_req;
    assign rd1     = sel ? rd_req : 1'b0;
    assign m_busy  = sel ? busy1  : busy4;
    assign m_done  = sel ? done1  : done4;
    assign m_frame = sel ? frame1 : frame4;
    assign m_sclk  = sel ? sclk1  : sclk4;
    assign m_sdo   = sel ? sdo1   : sdo4;

    always #5 clk = ~clk;

    lut4_cfg_readback #(.NUM_LUTS(4), .CLK_DIV(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .rd_req(rd4), .cfg_tables(cfg4),
        .busy(busy4), .done(done4), .frame_o(frame4), .sclk_o(sclk4), .sdo(sdo4)
    );

    lut4_cfg_readback #(.NUM_LUTS(1), .CLK_DIV(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .rd_req(rd1), .cfg_tables(cfg1),
        .busy(busy1), .done(done1), .frame_o(frame1), .sclk_o(sclk1), .sdo(sdo1)
    );

    int         checks = 0;
    int         passed = 0;
    logic [7:0] exp_q[$];
    logic       rx[$];
    int         n_busy, n_frame, n_done, done_at, last_busy, first_busy;
    int         sclk_err, idle_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_expected(input int n, input logic [63:0] tbl);
        logic [7:0]  cs;
        logic [15:0] t;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(n));
        cs = 8'(n);
        for (int i = 0; i < n; i++) begin
            t = tbl[i*16 +: 16];
            exp_q.push_back(t[15:8]);
            exp_q.push_back(t[7:0]);
            cs = cs ^ t[15:8] ^ t[7:0];
        end
        exp_q.push_back(cs);
    endtask

    function automatic logic [7:0] rx_byte(input int b);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) begin
            r[7-j] = (b*8 + j < rx.size()) ? rx[b*8 + j] : 1'bx;
        end
        return r;
    endfunction

    // kind: 0 none, 1 clear cfg, 2 extra rd_req, 3 drop ena, 4 async reset,
    //       5 rd_req during DONE, 6 rd_req in first idle cycle after DONE then return
    task automatic capture(input int kind, input int ev_bit, input int budget, input int cdiv);
        logic prev;
        bit   fired, after_done, abort_chk;
        rx.delete();
        n_busy = 0; n_frame = 0; n_done = 0; sclk_err = 0; idle_err = 0;
        done_at = -1; last_busy = -1; first_busy = -1;
        prev = 1'b0; fired = 0; after_done = 0; abort_chk = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            rd_req = 1'b0;
            if (abort_chk) begin
                chk("abort_outputs", {27'b0, m_busy, m_done, m_frame, m_sclk, m_sdo}, 32'd0);
                abort_chk = 0;
            end
            if (m_busy) begin
                if (m_sclk !== ((n_busy % cdiv) >= cdiv/2)) sclk_err++;
                n_busy++;
                last_busy = c;
                if (first_busy < 0) first_busy = c;
            end else if (m_sclk !== 1'b0 || m_sdo !== 1'b0) begin
                idle_err++;
            end
            if (m_frame) n_frame++;
            if (m_done) begin
                n_done++;
                done_at = c;
            end
            if (m_sclk && !prev) rx.push_back(m_sdo);
            prev = m_sclk;
            if (kind == 5 && m_done) rd_req = 1'b1;
            if (kind == 6 && after_done) begin
                rd_req = 1'b1;
                break;
            end
            if (kind == 6 && m_done) after_done = 1;
            if (!fired && ev_bit >= 0 && rx.size() == ev_bit) begin
                fired = 1;
                case (kind)
                    1: cfg4 = '0;
                    2: rd_req = 1'b1;
                    3: begin
                        ena = 1'b0;
                        abort_chk = 1;
                    end
                    4: begin
                        #2 rst_n = 1'b0;
                        #1 chk("async_reset_outputs",
                               {27'b0, m_busy, m_done, m_frame, m_sclk, m_sdo}, 32'd0);
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic check_frame(input string tag, input int nbytes);
        logic [7:0] e;
        chk({tag, "_len"}, rx.size(), nbytes * 8);
        for (int b = 0; b < nbytes; b++) begin
            e = exp_q.pop_front();
            chk($sformatf("%s_byte%0d", tag, b), rx_byte(b), e);
        end
    endtask

    initial begin
        cfg4 = {16'h0001, 16'h6996, 16'hFFFE, 16'h8000};
        cfg1 = 16'h1234;
        #1;
        chk("reset_outputs4", {27'b0, busy4, done4, frame4, sclk4, sdo4}, 32'd0);
        chk("reset_outputs1", {27'b0, busy1, done1, frame1, sclk1, sdo1}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ena   = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {31'b0, busy4}, 32'd0);

        // Basic frame; a request during the DONE cycle must not restart.
        @(negedge clk) rd_req = 1'b1;
        push_expected(4, cfg4);
        capture(5, -1, 240, 2);
        check_frame("basic", 11);
        chk("basic_csum", rx_byte(10), 32'h7B);
        chk("basic_busy_cycles", n_busy, 176);
        chk("basic_frame_cycles", n_frame, 176);
        chk("basic_done_count", n_done, 1);
        chk("basic_done_timing", done_at, last_busy + 1);
        chk("basic_sclk_shape", sclk_err, 0);
        chk("basic_idle_quiet", idle_err, 0);

        // Snapshot: tables cleared at bit 30 must not alter the frame.
        @(negedge clk) rd_req = 1'b1;
        push_expected(4, cfg4);
        capture(1, 30, 240, 2);
        check_frame("snap", 11);
        chk("snap_csum", rx_byte(10), 32'h7B);
        chk("snap_done_count", n_done, 1);
        cfg4 = {16'h0001, 16'h6996, 16'hFFFE, 16'h8000};

        // Second request while busy is ignored.
        @(negedge clk) rd_req = 1'b1;
        push_expected(4, cfg4);
        capture(2, 10, 420, 2);
        check_frame("busyign", 11);
        chk("busyign_busy_cycles", n_busy, 176);
        chk("busyign_done_count", n_done, 1);

        // Abort by dropping ena at bit 40.
        @(negedge clk) rd_req = 1'b1;
        capture(3, 40, 200, 2);
        chk("abort_bits", rx.size(), 40);
        chk("abort_busy_cycles", n_busy, 80);
        chk("abort_no_done", n_done, 0);
        ena = 1'b1;

        // Full frame after abort, then a request in the first idle cycle after DONE.
        @(negedge clk) rd_req = 1'b1;
        push_expected(4, cfg4);
        capture(6, -1, 300, 2);
        check_frame("after_abort", 11);
        chk("after_abort_busy_cycles", n_busy, 176);
        chk("after_abort_done_count", n_done, 1);

        push_expected(4, cfg4);
        capture(0, -1, 240, 2);
        check_frame("b2b", 11);
        chk("b2b_start_cycle", first_busy, 0);
        chk("b2b_done_count", n_done, 1);

        // Asynchronous reset in mid-frame.
        @(negedge clk) rd_req = 1'b1;
        capture(4, 20, 60, 2);
        chk("reset_bits", rx.size(), 20);
        chk("reset_no_done", n_done, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_busy_after", {31'b0, busy4}, 32'd0);
        chk("reset_state_idle", 32'(dut4.state), 32'(IDLE));

        // Request with ena low is ignored.
        ena = 1'b0;
        @(negedge clk) rd_req = 1'b1;
        capture(0, -1, 20, 2);
        chk("ena_low_req_busy", n_busy, 0);
        ena = 1'b1;

        // NUM_LUTS=1, CLK_DIV=4.
        sel = 1'b1;
        @(negedge clk) rd_req = 1'b1;
        push_expected(1, {48'b0, cfg1});
        capture(0, -1, 220, 4);
        check_frame("sweep", 5);
        chk("sweep_csum", rx_byte(4), 32'h27);
        chk("sweep_busy_cycles", n_busy, 160);
        chk("sweep_done_count", n_done, 1);
        chk("sweep_sclk_shape", sclk_err, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/lut4_cfg_readback.md
Name: lut4_cfg_readback

Overview:
Serial readback transmitter for the LUT4 test design. It snapshots the truth tables of all configured LUT4 cells and shifts them out on dedicated output pins as a framed, checksummed bitstream. It is the transmit-side counterpart of the serial configuration loader, so the bench or an external host can verify what was written. It sits inside the top-level user project between the LUT configuration registers and the uo_out/uio_out pin mux.

Parameters:
NUM_LUTS, 4, number of LUT4 truth tables to read back (1..15)
CLK_DIV, 2, clk cycles per serial bit; even, >=2

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  design-selected enable; low aborts any transfer
rd_req  input  1  one-cycle pulse, start readback
cfg_tables  input  16*NUM_LUTS  concatenated truth tables, LUT0 in bits [15:0]
busy  output  1  transfer in progress
done  output  1  one-cycle pulse, frame complete
frame_o  output  1  high for the whole frame (chip-select style)
sclk_o  output  1  serial bit clock
sdo  output  1  serial data, MSB first

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: busy=0, done=0, frame_o=0, sclk_o=0, sdo=0, FSM=IDLE, all counters 0.
- Frame format, MSB first, with every byte/word contiguous:
  - header 8'hA5
  - count byte = NUM_LUTS
  - NUM_LUTS x 16-bit tables, LUT0 first
  - checksum byte = XOR of the count byte and every table byte; the header is excluded.
- Frame length: 24 + 16*NUM_LUTS bits.
- FSM states: IDLE -> HDR -> CNT -> DATA -> CSUM -> DONE -> IDLE.
- IDLE:
  - A rd_req sampled at edge k with ena=1 snapshots cfg_tables into an internal register.
  - From k+1: busy=1, frame_o=1, sdo = first header bit (1), go to HDR.
- Bit timing:
  - Each bit is held for CLK_DIV cycles.
  - sclk_o=0 for the first CLK_DIV/2 cycles of the bit and 1 for the second half.
  - sdo changes only when sclk_o is 0; the receiver samples on the sclk_o rising edge.
- Counters:
  - Bit-phase counter: 0..CLK_DIV-1.
  - Bit index within the current field, which decrements.
  - LUT index: 0..NUM_LUTS-1.
- Checksum is accumulated byte-wise from the snapshot as the count byte and table bytes are sent.
- DATA -> CSUM after the last bit of LUT NUM_LUTS-1.
- CSUM -> DONE after the last checksum bit period.
- DONE (one cycle): done=1, busy=0, frame_o=0, sclk_o=0, sdo=0; next cycle IDLE.
- Boundaries:
  - rd_req while busy is ignored, with no restart.
  - cfg_tables changes mid-frame do not affect the frame (snapshot only).
  - ena=0 in any state forces IDLE next cycle with all outputs at reset values and no done pulse.
  - rd_req with ena=0 is ignored.
  - Asynchronous reset mid-frame returns all outputs to reset values immediately.
  - rd_req in the DONE cycle is ignored.
  - rd_req in the first IDLE cycle after DONE starts a new frame, so back-to-back frames are separated by at least one idle cycle.

Decomposition:
- Shared package lut4_pkg holds:
  - LUT_W=16
  - RB_HEADER=8'hA5
  - the FSM state enum rb_state_t
  - a frame-length helper function
- One sub-module is natural: lut4_rb_bitclk, the CLK_DIV phase counter. It emits sclk_o and a one-cycle bit_adv strobe at the end of each bit period.

Test Plan:
- Basic frame, NUM_LUTS=4, CLK_DIV=2, tables {LUT0..3}=16'h8000, 16'hFFFE, 16'h6996, 16'h0001, rd_req pulsed:
  - Bench samples on sclk_o rising edges and receives A5 04 80 00 FF FE 69 96 00 01 7B.
  - That is 88 bits; busy is high for 176 cycles; done pulses exactly once in the following cycle.
- Snapshot: change cfg_tables to all 16'h0000 at bit 30 of the frame above -> transmitted bytes are unchanged, checksum still 0x7B.
- Busy ignore: a second rd_req at bit 10 -> a single 88-bit frame and one done pulse; no second frame follows.
- Abort: drop ena at bit 40 -> the next cycle busy=0, frame_o=0, sdo=0, no done pulse. Raising ena and pulsing rd_req then yields a full correct frame.
- Async reset: assert rst_n=0 mid-frame between clock edges -> all outputs go to 0 before the next clk edge and the FSM is in IDLE after release.
- Parameter sweep, NUM_LUTS=1, CLK_DIV=4, table 16'h1234:
  - Bytes A5 01 12 34 27, i.e. 01^12^34=0x27.
  - 40 bits, busy for 160 cycles, sclk_o low 2 cycles and high 2 cycles per bit.
